// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the 16x-oversampled UART receiver.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit to the frame).
package uart_pkg;

  localparam int unsigned BIT_TICKS  = 16;
  localparam int unsigned HALF_TICKS = 8;

  localparam logic PARITYMODE_DEFAULT = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a one-cycle-delayed
// copy used to detect the falling edge that begins a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic rx_d_q, rx_d_d;

  // Next-state for the synchronizer chain and the delayed copy.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_d_d    = rx_s_q;
  end

  // Flops reset high so an idle line does not look like an edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_d_q    <= rx_d_d;
    end
  end

  assign rx_s = rx_s_q;
  assign fall = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 16x oversampling, mid-bit sampling.
// Optional feature macro: UART_RX_PARITY_EN (parity bit after the data bits,
// checked against XOR(data) ^ PARITYMODE). Without it, parity_err is 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic PARITYMODE = PARITYMODE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  rx_state_t  state_q;
  logic [7:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic [7:0] dataout_q;
  logic       rdsig_q;
  logic       frame_err_q;
  logic       busy_q;
`ifdef UART_RX_PARITY_EN
  logic       perr_pend_q;
  logic       parity_err_q;
`endif

  // The start sample lands half a bit after the edge; every later sample is a
  // full bit after the previous one, so cnt wraps at each sample point.
  logic half_hit;
  logic bit_hit;
  assign half_hit = (cnt_q == 8'(HALF_TICKS - 1));
  assign bit_hit  = (cnt_q == 8'(BIT_TICKS - 1));

  // Receive FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      dataout_q    <= '0;
      rdsig_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_q  <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rdsig_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (fall) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (half_hit) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DATA: begin
          if (bit_hit) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_hit) begin
            cnt_q       <= '0;
            perr_pend_q <= rx_s ^ (^shift_q) ^ PARITYMODE;
            state_q     <= STOP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
`endif
        STOP: begin
          if (bit_hit) begin
            cnt_q        <= '0;
            dataout_q    <= shift_q;
            frame_err_q  <= ~rx_s;
            rdsig_q      <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= perr_pend_q;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dataout   = dataout_q;
  assign rdsig     = rdsig_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  // Parity disabled: the parameter is kept for a uniform interface only.
  assign parity_err = PARITYMODE & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a scoreboard of expected bytes/flags and
// arrival cycles is filled by the sender and drained by the rdsig monitor.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int RD_OFS     = 169;
`else
  localparam int FRAME_BITS = 10;
  localparam int RD_OFS     = 153;
`endif
  localparam int FRAME_CYC = FRAME_BITS * 16;
  // Two synchronizer cycles from driving rx low to the detection cycle T0.
  localparam int LAT = 2 + RD_OFS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] dataout;
  logic       rdsig;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx #(.PARITYMODE(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .dataout    (dataout),
    .rdsig      (rdsig),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rd_count = 0;
  int   last_rd_cyc = 0;
  int   prev_rd_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rdsig pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rdsig) begin
      rd_count++;
      prev_rd_cyc = last_rd_cyc;
      last_rd_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rdsig: got rdsig at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_checks += 4;
        if (dataout !== e.data) begin
          n_fail++;
          $display("FAIL dataout: got %02h required %02h", dataout, e.data);
        end
        if (parity_err !== e.perr) begin
          n_fail++;
          $display("FAIL parity_err: got %b required %b (data %02h)", parity_err, e.perr, e.data);
        end
        if (frame_err !== e.ferr) begin
          n_fail++;
          $display("FAIL frame_err: got %b required %b (data %02h)", frame_err, e.ferr, e.data);
        end
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL rdsig_time: got cycle %0d required %0d", cyc, e.cyc);
        end
      end
    end
  end

  // Called on a negedge; drives one full frame, 16 clocks per bit.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input logic exp_perr, input logic exp_ferr);
    exp_t e;
    e.data = d;
    e.perr = exp_perr;
    e.ferr = exp_ferr;
    e.cyc  = cyc + LAT;
    sb.push_back(e);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    repeat (16) @(negedge clk);
`else
    if (pbit === 1'bx) rx = 1'b1;
`endif
    rx = stopb;
    repeat (16) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending rdsig, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dataout, rdsig, parity_err, frame_err, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %03h required 000",
               {dataout, rdsig, parity_err, frame_err, busy});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rd_count !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b rdsig_count=%0d required 0/0", busy, rd_count);
    end
  endtask

  task automatic test_basic();
    int n0;
    n0 = rd_count;
    @(negedge clk);
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b0, 1'b0);
    drain("basic");
    repeat (50) @(negedge clk);
    n_checks++;
    if (dataout !== 8'hA5 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got %02h/%b/%b required a5/0/0", dataout, parity_err, frame_err);
    end
    n_checks++;
    if (rd_count - n0 !== 1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d rdsig required 1", rd_count - n0);
    end
  endtask

  task automatic test_parity_err();
    @(negedge clk);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
`else
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    drain("parity");
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame_err();
    int n0;
    n0 = rd_count;
    @(negedge clk);
    send_frame(8'h3C, good_par(8'h3C), 1'b0, 1'b0, 1'b1);
    repeat (64) @(negedge clk);
    rx = 1'b1;
    drain("frame");
    repeat (250) @(negedge clk);
    n_checks++;
    if (rd_count - n0 !== 1) begin
      n_fail++;
      $display("FAIL frame_single: got %0d rdsig required 1", rd_count - n0);
    end
    n_checks++;
    if (busy !== 1'b0 || frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_idle: got busy=%b frame_err=%b required 0/1", busy, frame_err);
    end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = rd_count;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);   // T0+1
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_start: got %b required 1", busy);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);   // T0+9
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy_end: got %b required 0", busy);
    end
    repeat (200) @(negedge clk);
    n_checks++;
    if (rd_count - n0 !== 0 || frame_err !== 1'b1 || dataout !== 8'h3C) begin
      n_fail++;
      $display("FAIL glitch_no_rdsig: got count=%0d data=%02h ferr=%b required 0/3c/1",
               rd_count - n0, dataout, frame_err);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    send_frame(8'h55, good_par(8'h55), 1'b1, 1'b0, 1'b0);
    send_frame(8'hAA, good_par(8'hAA), 1'b1, 1'b0, 1'b0);
    drain("b2b");
    n_checks++;
    if (last_rd_cyc - prev_rd_cyc !== FRAME_CYC) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles required %0d", last_rd_cyc - prev_rd_cyc, FRAME_CYC);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_midframe_reset();
    int n0;
    n0 = rd_count;
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;                   // data bits of 0xFF
    repeat (66) @(negedge clk);  // T0+80
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_before: got %b required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({dataout, rdsig, parity_err, frame_err, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_async_outputs: got %03h required 000",
               {dataout, rdsig, parity_err, frame_err, busy});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    n_checks++;
    if (rd_count - n0 !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: got count=%0d busy=%b required 0/0", rd_count - n0, busy);
    end
    send_frame(8'h12, good_par(8'h12), 1'b1, 1'b0, 1'b0);
    drain("rst_next");
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_midframe_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
